udp_mux_arbiter: RTL and testbench

// - Packet-level round-robin arbiter that drives enable/select of the UDP TX mux (udp_mux_wrapper).
// - Grants one UDP source at a time, and holds the grant until that packet's payload tlast leaves the mux.
// - Observes sink-side header handshakes and source-side payload handshakes only. Never drives data.
// - Recovers from stalled packets with a no-progress timeout.

---
 rtl/udp_mux_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_udp_mux_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_mux_arbiter.sv
// ---------------------------------------------------------------------------
// UdpMuxArbiter (module udp_mux_arbiter)
//
// Purpose:
//   Packet-level round-robin arbiter that steers the enable/select inputs of
//   the UDP TX mux. One source owns the mux at a time. Ownership lasts from
//   the grant until that packet's payload tlast leaves the mux output. Only
//   handshakes are observed; no data passes through this block. A packet
//   that makes no progress for TIMEOUT_CYCLES cycles is abandoned so the
//   mux cannot stay locked to a dead source.
//
// Parameters:
//   S_COUNT         number of UDP sources (>= 2)
//   TIMEOUT_CYCLES  no-progress cycles before a grant is abandoned, 0 = off
//
// Ports:
//   clk          in   clock
//   reset_n      in   asynchronous reset, active low
//   s_hdr_valid  in   per-source header valid (mux sink hdr_valid)
//   s_hdr_ready  in   per-source header ready (mux sink hdr_ready)
//   m_tvalid     in   mux output payload tvalid
//   m_tready     in   mux output payload tready
//   m_tlast      in   mux output payload tlast
//   enable       out  mux enable, high only while waiting for the header
//   select       out  mux select, index of the current owner
//   grant        out  one-hot owner, zero when idle
//   busy         out  high while a source owns the mux
//   timeout      out  one-cycle pulse when a grant is abandoned
// ---------------------------------------------------------------------------
module udp_mux_arbiter #(
  parameter int S_COUNT        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [S_COUNT-1:0]         s_hdr_valid,
  input  logic [S_COUNT-1:0]         s_hdr_ready,
  input  logic                       m_tvalid,
  input  logic                       m_tready,
  input  logic                       m_tlast,
  output logic                       enable,
  output logic [$clog2(S_COUNT)-1:0] select,
  output logic [S_COUNT-1:0]         grant,
  output logic                       busy,
  output logic                       timeout
);

  localparam int SW = $clog2(S_COUNT);

  // A disabled timeout still needs a legal one-bit counter.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TO_LIMIT = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [SW-1:0] LAST_RESET = SW'(S_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_enable;
  logic [SW-1:0]       r_select;
  logic [S_COUNT-1:0]  r_grant;
  logic                r_busy;
  logic                r_timeout;
  logic [SW-1:0]       r_last;
  logic [TW-1:0]       r_timer;

  logic                w_beat;
  logic                w_beatLast;
  logic                w_hs;
  logic                w_progress;
  logic                w_expire;
  logic [TW-1:0]       w_timerNext;
  logic                w_reqFound;
  logic [SW-1:0]       w_winner;
  logic [S_COUNT-1:0]  w_winnerOneHot;

  assign enable  = r_enable;
  assign select  = r_select;
  assign grant   = r_grant;
  assign busy    = r_busy;
  assign timeout = r_timeout;

  // Handshake observations on the mux sink (header) and mux output (payload).
  assign w_beat     = m_tvalid & m_tready;
  assign w_beatLast = w_beat & m_tlast;
  assign w_hs       = s_hdr_valid[r_select] & s_hdr_ready[r_select];
  assign w_progress = w_hs | w_beat;

  // Expiry fires on the last allowed no-progress cycle; the counter itself
  // saturates so it can never wrap back into a false "fresh" value.
  assign w_expire    = TO_EN && (r_timer == TO_LIMIT);
  assign w_timerNext = (r_timer == {TW{1'b1}}) ? r_timer : r_timer + 1'b1;

  // Round-robin scan starting just after the most recently served source,
  // so the previous owner is considered last.
  always_comb begin
    int idx;
    idx        = 0;
    w_reqFound = 1'b0;
    w_winner   = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      idx = int'(r_last) + k;
      if (idx >= S_COUNT) begin
        idx = idx - S_COUNT;
      end
      if (!w_reqFound && s_hdr_valid[idx]) begin
        w_reqFound = 1'b1;
        w_winner   = SW'(idx);
      end
    end
  end

  assign w_winnerOneHot = {{(S_COUNT-1){1'b0}}, 1'b1} << w_winner;

  // Arbiter FSM with all outputs registered.
  // IDLE picks a winner, GRANT holds enable until exactly one header is
  // accepted, PAYLOAD keeps select frozen until the tlast beat drains.
  // "last" is only updated once a header is actually accepted (or the grant
  // times out), so an abandoned or pending grant does not skew fairness.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_enable  <= 1'b0;
      r_select  <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= LAST_RESET;
      r_timer   <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_reqFound) begin
            r_select <= w_winner;
            r_grant  <= w_winnerOneHot;
            r_enable <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (w_hs) begin
            // Header accepted: close the mux so no second header slips in.
            // A tlast beat in the same cycle means the packet is already out.
            r_enable <= 1'b0;
            r_last   <= r_select;
            r_timer  <= '0;
            if (w_beatLast) begin
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end else if (w_beat) begin
            r_timer <= '0;
          end else if (w_expire) begin
            r_enable  <= 1'b0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_last    <= r_select;
            r_timer   <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_timer <= w_timerNext;
          end
        end

        ST_PAYLOAD: begin
          if (w_beatLast) begin
            // Normal release takes priority over a coincident expiry.
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else if (w_progress) begin
            r_timer <= '0;
          end else if (w_expire) begin
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_last    <= r_select;
            r_timer   <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_timer <= w_timerNext;
          end
        end

        default: begin
          r_enable <= 1'b0;
          r_grant  <= '0;
          r_busy   <= 1'b0;
          r_timer  <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udp_mux_arbiter
//
// Purpose:
//   Self-checking bench for udp_mux_arbiter with four sources and a short
//   16-cycle timeout. A packet-level reference model (who owns the mux,
//   whether the header is still outstanding, who was served last, how long
//   since progress) predicts every output each cycle. Directed scenarios
//   pin the model with literal expectations, then randomized traffic with
//   stall phases exercises timeouts and coincident events.
// ---------------------------------------------------------------------------
module tb_udp_mux_arbiter;

  localparam int NSRC = 4;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NSRC-1:0] s_hdr_valid;
  logic [NSRC-1:0] s_hdr_ready;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic            enable;
  logic [1:0]      select;
  logic [NSRC-1:0] grant;
  logic            busy;
  logic            timeout;

  int checks = 0;
  int passes = 0;

  // Reference model: packet ownership view of the arbiter.
  int mOwner;
  bit mHdrPending;
  int mLast;
  int mSel;
  int mIdleCount;
  bit mPulse;

  udp_mux_arbiter #(
    .S_COUNT        (NSRC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_hdr_valid (s_hdr_valid),
    .s_hdr_ready (s_hdr_ready),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .enable      (enable),
    .select      (select),
    .grant       (grant),
    .busy        (busy),
    .timeout     (timeout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Back to the reset picture: nobody owns the mux, source 0 is first.
  task automatic modelReset();
    mOwner      = -1;
    mHdrPending = 1'b0;
    mLast       = NSRC - 1;
    mSel        = 0;
    mIdleCount  = 0;
    mPulse      = 1'b0;
  endtask

  // Advance the model by one clock using the inputs that the edge samples.
  task automatic modelAdvance(input logic [NSRC-1:0] v, input logic [NSRC-1:0] r,
                              input logic tv, input logic tr, input logic tl);
    bit beat;
    bit hs;
    bit found;
    int cand;
    beat   = tv && tr;
    hs     = v[mSel] && r[mSel];
    mPulse = 1'b0;
    if (mOwner < 0) begin
      mIdleCount = 0;
      found = 1'b0;
      for (int k = 1; k <= NSRC; k++) begin
        cand = (mLast + k) % NSRC;
        if (!found && v[cand]) begin
          found       = 1'b1;
          mOwner      = cand;
          mSel        = cand;
          mHdrPending = 1'b1;
        end
      end
    end else if (mHdrPending && hs) begin
      mLast       = mOwner;
      mHdrPending = 1'b0;
      mIdleCount  = 0;
      if (beat && tl) begin
        mOwner = -1;
      end
    end else if (!mHdrPending && beat && tl) begin
      mOwner     = -1;
      mIdleCount = 0;
    end else if (hs || beat) begin
      mIdleCount = 0;
    end else if (mIdleCount == TMO - 1) begin
      mPulse      = 1'b1;
      mLast       = mOwner;
      mOwner      = -1;
      mHdrPending = 1'b0;
      mIdleCount  = 0;
    end else begin
      mIdleCount = mIdleCount + 1;
    end
  endtask

  // Compare every DUT output against the model's prediction.
  task automatic checkOutput();
    logic [8:0] act;
    logic [8:0] exp;
    logic [3:0] expGrant;
    expGrant = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
    act = {enable, select, grant, busy, timeout};
    exp = {mHdrPending, 2'(mSel), expGrant, (mOwner >= 0), mPulse};
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL model-compare t=%0t actual en=%b sel=%0d grant=%b busy=%b to=%b expected en=%b sel=%0d grant=%b busy=%b to=%b",
               $time, act[8], act[7:6], act[5:2], act[1], act[0],
               exp[8], exp[7:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Literal expectation used to pin the model in directed scenarios.
  task automatic checkLit(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s t=%0t actual=%0d expected=%0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge take
  // them, then check the result at the next falling edge.
  task automatic applyStimulus(input logic [NSRC-1:0] v, input logic [NSRC-1:0] r,
                               input logic tv, input logic tr, input logic tl);
    s_hdr_valid = v;
    s_hdr_ready = r;
    m_tvalid    = tv;
    m_tready    = tr;
    m_tlast     = tl;
    modelAdvance(v, r, tv, tr, tl);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    bit stall;
    reset_n     = 1'b0;
    s_hdr_valid = '0;
    s_hdr_ready = '0;
    m_tvalid    = 1'b0;
    m_tready    = 1'b0;
    m_tlast     = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] reset values");
    checkLit("reset_enable", int'(enable), 0);
    checkLit("reset_grant", int'(grant), 0);
    checkLit("reset_busy", int'(busy), 0);
    checkOutput();

    $display("[TB] single request from source 2");
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkLit("req2_enable", int'(enable), 1);
    checkLit("req2_select", int'(select), 2);
    checkLit("req2_grant", int'(grant), 4);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
    checkLit("req2_enable_after_hs", int'(enable), 0);
    checkLit("req2_busy_after_hs", int'(busy), 1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);

    $display("[TB] release timing after tlast");
    applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1);
    checkLit("tlast_grant_m1", int'(grant), 0);
    checkLit("tlast_enable_m1", int'(enable), 0);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkLit("tlast_enable_m2", int'(enable), 1);
    checkLit("tlast_grant_m2", int'(grant), 1);

    $display("[TB] header and tlast in the same cycle");
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1);
    checkLit("zerolen_busy", int'(busy), 0);
    checkLit("zerolen_grant", int'(grant), 0);

    $display("[TB] timeout on stalled source 1");
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkLit("to_grant1", int'(grant), 2);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      applyStimulus(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
      if (i == TMO - 1) begin
        checkLit("to_not_yet", int'(timeout), 0);
        checkLit("to_busy_before", int'(busy), 1);
      end
    end
    checkLit("to_pulse", int'(timeout), 1);
    checkLit("to_busy_after", int'(busy), 0);
    checkLit("to_grant_after", int'(grant), 0);
    applyStimulus(4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkLit("to_skip_src1", int'(grant), 4);
    checkLit("to_pulse_single", int'(timeout), 0);

    $display("[TB] asynchronous reset during payload");
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkLit("areset_enable", int'(enable), 0);
    checkLit("areset_grant", int'(grant), 0);
    checkLit("areset_busy", int'(busy), 0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput();

    $display("[TB] round robin with all sources requesting");
    for (int p = 0; p < 5; p++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      checkLit("rr_grant", int'(grant), 1 << (p % NSRC));
      checkLit("rr_enable", int'(enable), 1);
      applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
      checkLit("rr_enable_after_hs", int'(enable), 0);
      for (int b = 0; b < 3; b++) begin
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1, (b == 2));
        if (b < 2) begin
          checkLit("rr_select_stable", int'(select), p % NSRC);
        end
      end
      checkLit("rr_busy_released", int'(busy), 0);
    end

    $display("[TB] single requester source 3 back to back");
    for (int p = 0; p < 3; p++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
      checkLit("single_enable", int'(enable), 1);
      checkLit("single_grant", int'(grant), 8);
      applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1);
      checkLit("single_gap_enable", int'(enable), 0);
      checkLit("single_no_timeout", int'(timeout), 0);
    end

    $display("[TB] randomized traffic");
    stall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [NSRC-1:0] v;
      logic [NSRC-1:0] r;
      logic tv;
      logic tr;
      logic tl;
      if (i % 150 == 0) begin
        stall = ($urandom_range(0, 2) == 0);
      end
      v  = 4'($urandom_range(0, 15));
      r  = stall ? 4'b0000 : 4'($urandom_range(0, 15));
      tv = stall ? 1'b0 : 1'($urandom_range(0, 1));
      tr = 1'($urandom_range(0, 1));
      tl = ($urandom_range(0, 3) == 0);
      applyStimulus(v, r, tv, tr, tl);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
